simon_control: RTL and testbench

Control FSM for the Simon game; it sits directly beside the Simon datapath and closes the loop with it. It consumes the datapath status flags (`legal`, `i_eq_ns`, `right_guess`) and a player submit button. It produces every datapath control strobe (`reset`, `rst_i`, `count_i`, `count_ns`, `m1`–`m4`) plus win/lose indication. It sequences four phases: pattern entry, timed playback, player repeat, and game over.

---
 rtl/simon_control.sv | 149 ++++++++++++++
 tb/tb_simon_control.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/simon_control.sv
// Simon game control FSM: sequences pattern entry, timed playback, player repeat and game over.
// Strobes are Mealy on the current state plus submit edge and datapath flags; everything else is registered.
module simon_control #(
  parameter int DWELL      = 4,
  parameter int MAX_ROUNDS = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic submit,
  input  logic legal,
  input  logic i_eq_ns,
  input  logic right_guess,
  output logic reset,
  output logic rst_i,
  output logic count_i,
  output logic count_ns,
  output logic m1,
  output logic m2,
  output logic m3,
  output logic m4,
  output logic win,
  output logic lose
);

  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic [2:0] {
    S_INPUT,
    S_PLAY,
    S_PLAY_CHK,
    S_REPEAT,
    S_REP_CHK,
    S_DONE,
    S_DONE_CHK
  } state_t;

  state_t          state_q, state_d;
  logic            sub_q;
  logic [6:0]      rounds_q, rounds_d;
  logic [DW-1:0]   dwell_q, dwell_d;
  logic            win_q, win_d;
  logic            lose_q, lose_d;
  logic            go;
  logic            dwell_end;

  assign go        = submit & ~sub_q;
  assign dwell_end = (dwell_q == DW'(DWELL - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_INPUT;
      sub_q    <= 1'b0;
      rounds_q <= '0;
      dwell_q  <= '0;
      win_q    <= 1'b0;
      lose_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sub_q    <= submit;
      rounds_q <= rounds_d;
      dwell_q  <= dwell_d;
      win_q    <= win_d;
      lose_q   <= lose_d;
    end
  end

  // Dwell defaults to zero, so it is already clear on every entry to PLAY or DONE.
  always_comb begin
    state_d  = state_q;
    rounds_d = rounds_q;
    dwell_d  = '0;
    win_d    = win_q;
    lose_d   = lose_q;
    rst_i    = 1'b0;
    count_i  = 1'b0;
    count_ns = 1'b0;

    case (state_q)
      S_INPUT: begin
        if (go && legal) begin
          count_ns = 1'b1;
          rst_i    = 1'b1;
          rounds_d = rounds_q + 7'd1;
          state_d  = S_PLAY;
        end
      end
      S_PLAY, S_DONE: begin
        if (dwell_end) begin
          count_i = 1'b1;
          state_d = (state_q == S_PLAY) ? S_PLAY_CHK : S_DONE_CHK;
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
      S_PLAY_CHK: begin
        if (i_eq_ns) begin
          rst_i   = 1'b1;
          state_d = S_REPEAT;
        end else begin
          state_d = S_PLAY;
        end
      end
      S_REPEAT: begin
        if (go) begin
          if (right_guess) begin
            count_i = 1'b1;
            state_d = S_REP_CHK;
          end else begin
            lose_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_REP_CHK: begin
        if (i_eq_ns) begin
          if (rounds_q == 7'(MAX_ROUNDS)) begin
            win_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_INPUT;
          end
        end else begin
          state_d = S_REPEAT;
        end
      end
      S_DONE_CHK: begin
        // Game over never exits on its own; it just rewinds the index to loop the sequence.
        if (i_eq_ns) rst_i = 1'b1;
        state_d = S_DONE;
      end
      default: state_d = S_INPUT;
    endcase

    if (rst) begin
      rst_i    = 1'b0;
      count_i  = 1'b0;
      count_ns = 1'b0;
    end
  end

  assign reset = rst;
  assign m1    = (state_q == S_INPUT);
  assign m2    = (state_q == S_PLAY)   || (state_q == S_PLAY_CHK);
  assign m3    = (state_q == S_REPEAT) || (state_q == S_REP_CHK);
  assign m4    = (state_q == S_DONE)   || (state_q == S_DONE_CHK);
  assign win   = win_q & ~rst;
  assign lose  = lose_q & ~rst;

endmodule

// File: tb/tb_simon_control.sv
// Bench for simon_control: a small datapath model closes the loop, and randomized games are checked
// against cycle counts and result flags derived from the game rules.
module tb_simon_control;
  localparam int DWELL = 4;
  localparam int MAXR  = 3;
  localparam int SLOT  = DWELL + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, submit;
  logic [3:0] sw;
  logic       legal, i_eq_ns, right_guess;
  logic       reset, rst_i, count_i, count_ns, m1, m2, m3, m4, win, lose;

  simon_control #(.DWELL(DWELL), .MAX_ROUNDS(MAXR)) dut (
    .clk(clk), .rst(rst), .submit(submit), .legal(legal), .i_eq_ns(i_eq_ns),
    .right_guess(right_guess), .reset(reset), .rst_i(rst_i), .count_i(count_i),
    .count_ns(count_ns), .m1(m1), .m2(m2), .m3(m3), .m4(m4), .win(win), .lose(lose)
  );

  // Minimal datapath: sequence store, sequence count, playback index.
  logic [7:0] dp_ns, dp_i;
  logic [3:0] dp_seq [0:127];
  assign legal       = (sw == 4'b0001) || (sw == 4'b0010) || (sw == 4'b0100) || (sw == 4'b1000);
  assign i_eq_ns     = (dp_i == dp_ns);
  assign right_guess = (sw == dp_seq[dp_i[6:0]]);

  always @(posedge clk) begin
    if (reset) begin
      dp_ns <= 8'd0;
      dp_i  <= 8'd0;
    end else begin
      if (m1 && count_ns) begin
        dp_seq[dp_ns[6:0]] <= sw;
        dp_ns <= dp_ns + 8'd1;
      end
      if (rst_i)        dp_i <= 8'd0;
      else if (count_i) dp_i <= dp_i + 8'd1;
    end
  end

  int n_cmp = 0;
  int n_err = 0;
  logic [3:0] exp_seq [$];

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one cycle's inputs just after the falling edge, then sample the settled outputs.
  task automatic step(input logic r, input logic s, input logic [3:0] w);
    @(negedge clk);
    rst    = r;
    submit = s;
    sw     = w;
    #1;
    chk("mode_onehot", int'($onehot({m1, m2, m3, m4})), 1);
    chk("reset_eq_rst", int'(reset), int'(r));
  endtask

  task automatic done_phase(input int r, input bit lost, input int k);
    int w, first_off, n_ci, n_ri, bad_hold, bad_ci, bad_ri;
    w = 3 * r * SLOT;
    first_off = DWELL + (r - k - 1) * SLOT;
    n_ci = 0; n_ri = 0; bad_hold = 0; bad_ci = 0; bad_ri = 0;
    for (int t = 0; t < w; t++) begin
      if (t > 0) step(1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      if (!m4 || (lose !== lost) || (win !== !lost) || count_ns) bad_hold++;
      if (count_i) begin
        n_ci++;
        if ((t % SLOT) != DWELL - 1) bad_ci++;
      end
      if (rst_i) begin
        n_ri++;
        if (t < first_off || ((t - first_off) % (r * SLOT)) != 0) bad_ri++;
      end
    end
    chk("done_hold", bad_hold, 0);
    chk("done_count_i_n", n_ci, 3 * r);
    chk("done_count_i_phase", bad_ci, 0);
    if (lost) begin
      chk("done_rst_i_n", n_ri, 3);
      chk("done_rst_i_phase", bad_ri, 0);
    end
  endtask

  // lose_round==0 plays to a win; otherwise guess lose_step of lose_round is wrong.
  task automatic play_game(input int lose_round, input int lose_step);
    int cnt, n_ci, first_ci, n_cns;
    logic [3:0] w, g;
    bit wrong;
    exp_seq.delete();
    for (int r = 1; r <= MAXR; r++) begin
      repeat ($urandom_range(0, 2)) begin
        step(1'b0, 1'b0, 4'($urandom_range(0, 15)));
        chk("input_idle_m1", int'(m1), 1);
      end
      if ($urandom_range(0, 1) == 1) begin
        step(1'b0, 1'b1, 4'b0011);
        chk("illegal_no_count_ns", int'(count_ns), 0);
        step(1'b0, 1'b0, 4'b0011);
        chk("illegal_stay_m1", int'(m1), 1);
      end
      w = 4'(1 << $urandom_range(0, 3));
      exp_seq.push_back(w);
      step(1'b0, 1'b1, w);
      chk("accept_count_ns", int'(count_ns), 1);
      chk("accept_rst_i", int'(rst_i), 1);
      chk("accept_m1", int'(m1), 1);

      step(1'b0, 1'b0, w);
      chk("play_entry_m2", int'(m2), 1);
      cnt = 0; n_ci = 0; first_ci = -1; n_cns = 0;
      while (!m3 && cnt < 400) begin
        if (count_i) begin
          n_ci++;
          if (first_ci < 0) first_ci = cnt;
        end
        n_cns += int'(count_ns);
        cnt++;
        step(1'b0, (cnt < DWELL - 2) ? 1'($urandom_range(0, 1)) : 1'b0, 4'($urandom_range(0, 15)));
      end
      chk("play_cycles", cnt, r * SLOT);
      chk("play_count_i_n", n_ci, r);
      chk("play_first_count_i", first_ci, DWELL - 1);
      chk("play_no_count_ns", n_cns, 0);

      for (int k = 0; k < r; k++) begin
        repeat ($urandom_range(0, 2)) begin
          step(1'b0, 1'b0, 4'($urandom_range(0, 15)));
          chk("repeat_wait_m3", int'(m3), 1);
        end
        wrong = (r == lose_round) && (k == lose_step);
        g = wrong ? {exp_seq[k][2:0], exp_seq[k][3]} : exp_seq[k];
        step(1'b0, 1'b1, g);
        chk("guess_count_i", int'(count_i), wrong ? 0 : 1);
        step(1'b0, 1'b0, g);
        if (wrong) begin
          chk("lose_m4", int'(m4), 1);
          chk("lose_flag", int'(lose), 1);
          chk("lose_no_win", int'(win), 0);
          done_phase(r, 1'b1, k);
          return;
        end
        chk("rep_chk_m3", int'(m3), 1);
        step(1'b0, 1'b0, g);
        if (k < r - 1) begin
          chk("repeat_next_m3", int'(m3), 1);
        end else if (r == MAXR) begin
          chk("win_m4", int'(m4), 1);
          chk("win_flag", int'(win), 1);
          chk("win_no_lose", int'(lose), 0);
          done_phase(r, 1'b0, 0);
          return;
        end else begin
          chk("round_back_m1", int'(m1), 1);
        end
      end
    end
    chk("game_never_ended", 0, 1);
  endtask

  initial begin
    int lr, ls;
    rst = 1'b1; submit = 1'b0; sw = 4'b0000;
    for (int a = 0; a < 128; a++) dp_seq[a] = 4'b0000;

    // Reset with submit held and a legal pattern: exactly one go on release.
    step(1'b1, 1'b1, 4'b0100);
    chk("rst_reset_hi", int'(reset), 1);
    chk("rst_no_strobes", int'({rst_i, count_i, count_ns}), 0);
    chk("rst_no_result", int'({win, lose}), 0);
    step(1'b1, 1'b1, 4'b0100);
    step(1'b0, 1'b1, 4'b0100);
    chk("post_rst_m1", int'(m1), 1);
    chk("post_rst_reset_lo", int'(reset), 0);
    chk("held_go_count_ns", int'(count_ns), 1);
    chk("held_go_rst_i", int'(rst_i), 1);
    step(1'b0, 1'b1, 4'b0100);
    chk("held_go_m2", int'(m2), 1);
    step(1'b0, 1'b1, 4'b0100);
    step(1'b0, 1'b1, 4'b0100);
    // Reset lands on the last dwell cycle of PLAY, where count_i would otherwise fire.
    step(1'b1, 1'b1, 4'b0100);
    chk("midplay_rst_no_strobes", int'({rst_i, count_i, count_ns}), 0);
    step(1'b0, 1'b0, 4'b0011);
    chk("midplay_rst_m1", int'(m1), 1);
    chk("midplay_rst_result", int'({win, lose}), 0);
    step(1'b0, 1'b1, 4'b0011);
    chk("illegal_go_no_write", int'(count_ns), 0);
    step(1'b0, 1'b1, 4'b0100);
    chk("held_no_second_go", int'(count_ns), 0);
    chk("held_still_m1", int'(m1), 1);
    step(1'b0, 1'b0, 4'b0100);

    play_game(1, 0);
    step(1'b1, 1'b0, 4'b0000);
    chk("game_rst_strobes", int'({rst_i, count_i, count_ns}), 0);
    chk("game_rst_result", int'({win, lose}), 0);
    play_game(0, 0);
    for (int gm = 0; gm < 4; gm++) begin
      step(1'b1, 1'b0, 4'b0000);
      chk("game_rst_result", int'({win, lose}), 0);
      lr = $urandom_range(0, MAXR);
      ls = (lr > 0) ? $urandom_range(0, lr - 1) : 0;
      play_game(lr, ls);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
